// File: rtl/vga_fb_arb.sv
// Framebuffer access scheduler: arbitrates one single-port framebuffer between
// a scan-out prefetcher (feeding a small pixel FIFO) and CPU pixel writes.
module vga_fb_arb #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WM     = 2
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [23:0]       pix_data,
  output logic              underflow,
  input  logic              cpu_wr_valid,
  output logic              cpu_wr_ready,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [23:0]       cpu_wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   fetch_addr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic                inflight_reg;
  logic                underflow_reg;
  logic [23:0]         fifo_mem [FIFO_DEPTH];

  logic [OCC_W-1:0]    occ;
  logic                fetch_elig;
  logic                fetch_urgent;
  logic                grant_fetch;
  logic                grant_cpu;
  logic                push;
  logic                pop;

  // The in-flight read counts toward occupancy so back-to-back issues never overfill.
  assign occ          = OCC_W'(count_reg) + OCC_W'(inflight_reg);
  assign fetch_elig   = (state_reg == S_FETCH) && (occ < OCC_W'(FIFO_DEPTH)) && !frame_start;
  assign fetch_urgent = fetch_elig && (occ <= OCC_W'(LOW_WM));

  // Grants are masked by reset so a pending CPU request drops the instant reset asserts.
  assign grant_fetch  = !reset && (fetch_urgent || (fetch_elig && !cpu_wr_valid));
  assign grant_cpu    = !reset && cpu_wr_valid && !fetch_urgent;

  assign push = inflight_reg && !frame_start;
  assign pop  = pix_rd && (count_reg != '0) && !frame_start;

  always_comb begin
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    cpu_wr_ready = 1'b0;
    if (grant_fetch) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr_reg;
    end else if (grant_cpu) begin
      mem_en       = 1'b1;
      mem_we       = 1'b1;
      mem_addr     = cpu_wr_addr;
      mem_wdata    = cpu_wr_data;
      cpu_wr_ready = 1'b1;
    end
  end

  assign pix_data  = (count_reg != '0) ? fifo_mem[rd_ptr_reg] : 24'd0;
  assign underflow = underflow_reg;

  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= mem_rdata;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      fetch_addr_reg <= '0;
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      inflight_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      inflight_reg <= grant_fetch;
      if (frame_start) begin
        state_reg      <= S_FETCH;
        fetch_addr_reg <= '0;
        count_reg      <= '0;
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
        underflow_reg  <= 1'b0;
      end else begin
        // The address parks on the last pixel; only a new frame restarts it.
        if (grant_fetch) begin
          if (fetch_addr_reg == LAST_ADDR) begin
            state_reg <= S_DONE;
          end else begin
            fetch_addr_reg <= fetch_addr_reg + 1'b1;
          end
        end
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
        if (pix_rd && (count_reg == '0)) begin
          underflow_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arb.sv
// Scoreboard bench for vga_fb_arb on a 16x2 frame with an 8-entry FIFO.
module tb_vga_fb_arb;

  localparam int AW = 6;

  logic          pclk;
  logic          reset;
  logic          frame_start;
  logic          pix_rd;
  logic [23:0]   pix_data;
  logic          underflow;
  logic          cpu_wr_valid;
  logic          cpu_wr_ready;
  logic [AW-1:0] cpu_wr_addr;
  logic [23:0]   cpu_wr_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_wdata;
  logic [23:0]   mem_rdata;

  logic [23:0]   mem_base;
  logic [AW-1:0] exp_addr[$];
  logic [23:0]   exp_pix[$];
  int            n_vec;
  int            n_err;

  vga_fb_arb #(
    .H_ACTIVE(16), .V_ACTIVE(2), .ADDR_W(AW), .FIFO_DEPTH(8), .LOW_WM(2)
  ) dut (
    .pclk(pclk), .reset(reset), .frame_start(frame_start), .pix_rd(pix_rd),
    .pix_data(pix_data), .underflow(underflow),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Framebuffer model: word n holds mem_base | n, returned the cycle after issue.
  always @(posedge pclk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_base | 24'(mem_addr);
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = 6'd9;
    cpu_wr_data  = 24'h777777;
    #2;
    n_vec++; if (cpu_wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", cpu_wr_ready); end
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    n_vec++; if (pix_data !== 24'd0) begin n_err++; $display("FAIL reset_pix_data: got %h want 0", pix_data); end
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    step();
    reset = 1'b0;
    cpu_wr_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL idle_mem_en: got %b want 0", mem_en); end
      step();
    end
  endtask

  task automatic test_underflow();
    pix_rd = 1'b1;
    @(negedge pclk);
    n_vec++; if (pix_data !== 24'd0) begin n_err++; $display("FAIL uf_pix_data: got %h want 0", pix_data); end
    step();
    pix_rd = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge pclk);
      n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky: got %b want 1", underflow); end
      step();
    end
    frame_start = 1'b1;
    pix_rd = 1'b1;
    step();
    frame_start = 1'b0;
    pix_rd = 1'b0;
    @(negedge pclk);
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear: got %b want 0", underflow); end
    n_vec++; if (pix_data !== 24'd0) begin n_err++; $display("FAIL uf_clear_pix: got %h want 0", pix_data); end
  endtask

  task automatic test_cold_fill();
    logic [AW-1:0] a;
    mem_base = 24'h000000;
    exp_addr.delete();
    for (int i = 0; i < 8; i++) exp_addr.push_back(AW'(i));
    step();
    frame_start = 1'b1;
    @(negedge pclk);
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL fill_c0_mem_en: got %b want 0", mem_en); end
    for (int c = 1; c <= 11; c++) begin
      step();
      frame_start = 1'b0;
      @(negedge pclk);
      if (c <= 8) begin
        a = exp_addr.pop_front();
        n_vec++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== a) begin
          n_err++;
          $display("FAIL fill_read c%0d: got en=%b we=%b addr=%0d want en=1 we=0 addr=%0d", c, mem_en, mem_we, mem_addr, a);
        end
      end else begin
        n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL fill_stop c%0d: got en=%b want 0", c, mem_en); end
      end
      if (c == 3) begin
        n_vec++; if (pix_data !== 24'd0) begin n_err++; $display("FAIL fill_first_pix: got %h want 0", pix_data); end
      end
    end
  endtask

  task automatic test_streaming();
    logic [AW-1:0] a;
    logic [23:0]   e;
    for (int i = 8; i < 32; i++) exp_addr.push_back(AW'(i));
    for (int s = 0; s < 32; s++) begin
      step();
      pix_rd = 1'b1;
      exp_pix.push_back(24'(s));
      @(negedge pclk);
      e = exp_pix.pop_front();
      $display("stream pop %0d: pix_data=%h expected=%h", s, pix_data, e);
      n_vec++; if (pix_data !== e) begin n_err++; $display("FAIL stream_pix %0d: got %h want %h", s, pix_data, e); end
      if (mem_en === 1'b1) begin
        n_vec++;
        if (exp_addr.size() == 0) begin
          n_err++;
          $display("FAIL stream_extra_read: got addr=%0d want no read", mem_addr);
        end else begin
          a = exp_addr.pop_front();
          if (mem_we !== 1'b0 || mem_addr !== a) begin
            n_err++;
            $display("FAIL stream_read: got we=%b addr=%0d want we=0 addr=%0d", mem_we, mem_addr, a);
          end
        end
      end
    end
    step();
    pix_rd = 1'b0;
    n_vec++; if (exp_addr.size() != 0) begin n_err++; $display("FAIL stream_reads_left: got %0d want 0", exp_addr.size()); end
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL done_no_read: got en=%b want 0", mem_en); end
      n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL stream_underflow: got %b want 0", underflow); end
      step();
    end
  endtask

  task automatic test_arbitration();
    logic [23:0] e;
    mem_base = 24'hA50000;
    frame_start = 1'b1;
    @(negedge pclk);
    for (int c = 1; c <= 10; c++) begin
      step();
      frame_start  = 1'b0;
      cpu_wr_valid = (c >= 6 && c <= 9);
      pix_rd       = (c >= 7 && c <= 9);
      cpu_wr_addr  = 6'd40;
      cpu_wr_data  = 24'h123456;
      if (pix_rd) exp_pix.push_back(24'hA50000 + 24'(c - 7));
      @(negedge pclk);
      if (c <= 5) begin
        n_vec++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(c - 1)) begin
          n_err++;
          $display("FAIL arb_fill c%0d: got en=%b we=%b addr=%0d want en=1 we=0 addr=%0d", c, mem_en, mem_we, mem_addr, c - 1);
        end
      end else if (c <= 9) begin
        n_vec++;
        if (cpu_wr_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd40 || mem_wdata !== 24'h123456) begin
          n_err++;
          $display("FAIL arb_cpu c%0d: got rdy=%b en=%b we=%b addr=%0d wd=%h want 1 1 1 40 123456", c, cpu_wr_ready, mem_en, mem_we, mem_addr, mem_wdata);
        end
      end else begin
        n_vec++;
        if (cpu_wr_ready !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 6'd5) begin
          n_err++;
          $display("FAIL arb_urgent: got rdy=%b en=%b we=%b addr=%0d want 0 1 0 5", cpu_wr_ready, mem_en, mem_we, mem_addr);
        end
      end
      if (c >= 7 && c <= 9) begin
        e = exp_pix.pop_front();
        n_vec++; if (pix_data !== e) begin n_err++; $display("FAIL arb_pix c%0d: got %h want %h", c, pix_data, e); end
      end
    end
  endtask

  task automatic test_flush();
    step();
    frame_start  = 1'b1;
    cpu_wr_valid = 1'b0;
    pix_rd       = 1'b0;
    @(negedge pclk);
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL flush_no_issue: got en=%b want 0", mem_en); end
    for (int c = 12; c <= 14; c++) begin
      step();
      frame_start = 1'b0;
      @(negedge pclk);
      n_vec++;
      if (mem_en !== 1'b1 || mem_addr !== AW'(c - 12)) begin
        n_err++;
        $display("FAIL flush_restart c%0d: got en=%b addr=%0d want en=1 addr=%0d", c, mem_en, mem_addr, c - 12);
      end
      n_vec++;
      if (pix_data !== ((c == 14) ? 24'hA50000 : 24'd0)) begin
        n_err++;
        $display("FAIL flush_pix c%0d: got %h want %h", c, pix_data, (c == 14) ? 24'hA50000 : 24'd0);
      end
    end
  endtask

  task automatic test_async_reset();
    step();
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = 6'd7;
    cpu_wr_data  = 24'hC0FFEE;
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (pix_data !== 24'd0 || underflow !== 1'b0 || cpu_wr_ready !== 1'b0 || mem_en !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 24'd0) begin
      n_err++;
      $display("FAIL async_reset: got pix=%h uf=%b rdy=%b en=%b we=%b addr=%0d wd=%h want all 0",
               pix_data, underflow, cpu_wr_ready, mem_en, mem_we, mem_addr, mem_wdata);
    end
    step();
    reset = 1'b0;
    cpu_wr_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      n_vec++; if (mem_en !== 1'b0 || pix_data !== 24'd0) begin n_err++; $display("FAIL post_reset_idle: got en=%b pix=%h want 0 0", mem_en, pix_data); end
      step();
    end
    cpu_wr_valid = 1'b1;
    @(negedge pclk);
    n_vec++;
    if (cpu_wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd7 || mem_wdata !== 24'hC0FFEE) begin
      n_err++;
      $display("FAIL idle_cpu_write: got rdy=%b we=%b addr=%0d wd=%h want 1 1 7 c0ffee", cpu_wr_ready, mem_we, mem_addr, mem_wdata);
    end
    step();
    cpu_wr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b1;
    frame_start  = 1'b0;
    pix_rd       = 1'b0;
    cpu_wr_valid = 1'b0;
    cpu_wr_addr  = '0;
    cpu_wr_data  = '0;
    mem_base     = '0;
    test_reset();
    test_underflow();
    test_cold_fill();
    test_streaming();
    test_arbitration();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
